// File: rtl/us_cmd_pkg.sv
// Shared types, command-word bit layout and encoder for the ultrasonic
// command transmitter.
package us_cmd_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_RECV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_WAKE  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_GAP   = 3'd4,
    ST_SHUT  = 3'd5
  } state_e;

  localparam int BIT_ON      = 0;
  localparam int BIT_OFF     = 1;
  localparam int BIT_INC     = 2;
  localparam int BIT_DEC     = 3;
  localparam int BIT_RECV    = 4;
  localparam int BIT_SEND    = 5;
  localparam int BIT_VALID   = 6;
  localparam int BIT_AMT_LSB = 7;
  localparam int CMD_W       = 15;

  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t IDLE_WORD = 15'h0001;
  localparam cmd_t OFF_WORD  = 15'h0002;

  typedef struct packed {
    op_e        op;
    logic [7:0] amount;
  } req_t;

  // Amount is only carried for INC/DEC; HOLD and RECV send it as zero.
  function automatic cmd_t encode_cmd(op_e op, logic [7:0] amount);
    cmd_t w;
    w            = '0;
    w[BIT_ON]    = 1'b1;
    w[BIT_VALID] = 1'b1;
    case (op)
      OP_INC: begin
        w[BIT_INC]           = 1'b1;
        w[BIT_SEND]          = 1'b1;
        w[BIT_AMT_LSB +: 8]  = amount;
      end
      OP_DEC: begin
        w[BIT_DEC]           = 1'b1;
        w[BIT_SEND]          = 1'b1;
        w[BIT_AMT_LSB +: 8]  = amount;
      end
      OP_HOLD: w[BIT_SEND] = 1'b1;
      default: w[BIT_RECV] = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/us_cmd_transmitter_if.sv
// Request channel into the command transmitter.
// A request transfers on any rising clk edge where req_valid && req_ready;
// req_op/req_amount must stay stable while req_valid is high and req_ready is low.
interface us_cmd_transmitter_if;
  import us_cmd_pkg::*;

  logic       req_valid;
  logic       req_ready;
  op_e        req_op;
  logic [7:0] req_amount;

  modport master (output req_valid, output req_op, output req_amount, input req_ready);
  modport slave  (input req_valid, input req_op, input req_amount, output req_ready);
endinterface

// File: rtl/us_cmd_fifo.sv
// Synchronous request FIFO (power-of-2 depth) with full/empty flags.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module us_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/us_cmd_transmitter.sv
// Host-side ultrasonic command transmitter: buffers requests, encodes and holds
// command words, tracks outstanding send-orders. US_TX_STATS_EN adds stat counters.
module us_cmd_transmitter
  import us_cmd_pkg::*;
#(
  parameter int DATA_WIDTH  = 15,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_ORDERS  = 5,
  parameter int SETTLE      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  us_cmd_transmitter_if.slave   req,
  input  logic                  no_order,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  busy,
  output logic [2:0]            outstanding,
  output logic                  drop_err,
  output state_e                dbg_state
`ifdef US_TX_STATS_EN
  ,
  output logic [15:0]           stat_sent,
  output logic [15:0]           stat_drop,
  output logic [15:0]           stat_stall
`endif
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = $clog2(SETTLE + 1);

  state_e          state_q, state_d;
  req_t            head;
  logic            fifo_full, fifo_empty;
  logic            pop, issue_go, send_go, below_max;
  logic [HW-1:0]   hold_q;
  logic            shut_pend_q;
  op_e             cur_op_q;
  logic [7:0]      cur_amt_q;
  logic [SW-1:0]   settle_q;
  logic [2:0]      out_q, out_d;
  cmd_t            word;

  assign req.req_ready = !fifo_full && rst_n;

  us_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(req_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req.req_valid && req.req_ready),
    .pop   (pop),
    .wdata ({req.req_op, req.req_amount}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign below_max = (out_q < 3'(MAX_ORDERS));
  assign send_go   = issue_go && (head.op != OP_RECV);

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    issue_go = 1'b0;
    drop_err = 1'b0;
    case (state_q)
      ST_OFF:  if (en) state_d = ST_WAKE;
      ST_WAKE: state_d = ST_IDLE;
      ST_IDLE: begin
        if (!en) begin
          state_d = ST_SHUT;
        end else if (!fifo_empty) begin
          if (head.op == OP_RECV) begin
            pop = 1'b1;
            if (out_q != 3'd0) begin
              issue_go = 1'b1;
              state_d  = ST_ISSUE;
            end else begin
              drop_err = 1'b1;
            end
          end else if (below_max) begin
            pop      = 1'b1;
            issue_go = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      // A shutdown request during the hold is remembered and honoured afterwards.
      ST_ISSUE: if (hold_q == HW'(HOLD_CYCLES - 1))
                  state_d = (shut_pend_q || !en) ? ST_SHUT : ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      ST_SHUT: state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
  end

  // Increment wins over a same-cycle clear; OFF pins the count at zero.
  always_comb begin
    out_d = out_q;
    if (no_order && (settle_q >= SW'(SETTLE))) out_d = '0;
    if (send_go && (out_d != 3'(MAX_ORDERS)))  out_d = out_d + 3'd1;
    if (state_d == ST_OFF)                     out_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      hold_q      <= '0;
      shut_pend_q <= 1'b0;
      cur_op_q    <= OP_HOLD;
      cur_amt_q   <= '0;
      settle_q    <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= (state_q == ST_ISSUE && state_d == ST_ISSUE) ? hold_q + 1'b1 : '0;
      shut_pend_q <= (state_q == ST_ISSUE) && (shut_pend_q || !en);
      if (issue_go) begin
        cur_op_q  <= head.op;
        cur_amt_q <= head.amount;
      end
      if (send_go)                       settle_q <= '0;
      else if (settle_q != SW'(SETTLE))  settle_q <= settle_q + 1'b1;
      out_q       <= out_d;
    end
  end

  always_comb begin
    word = '0;
    case (state_q)
      ST_WAKE, ST_IDLE, ST_GAP: word = IDLE_WORD;
      ST_ISSUE:                 word = encode_cmd(cur_op_q, cur_amt_q);
      ST_SHUT:                  word = OFF_WORD;
      default:                  word = '0;
    endcase
    received_data            = '0;
    received_data[CMD_W-1:0] = word;
  end

  assign busy        = !(state_q == ST_OFF || state_q == ST_IDLE) || !fifo_empty;
  assign outstanding = out_q;
  assign dbg_state   = state_q;

`ifdef US_TX_STATS_EN
  logic stall_cyc;
  assign stall_cyc = (state_q == ST_IDLE) && en && !fifo_empty &&
                     (head.op != OP_RECV) && !below_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent  <= '0;
      stat_drop  <= '0;
      stat_stall <= '0;
    end else begin
      if (issue_go  && stat_sent  != 16'hFFFF) stat_sent  <= stat_sent  + 16'd1;
      if (drop_err  && stat_drop  != 16'hFFFF) stat_drop  <= stat_drop  + 16'd1;
      if (stall_cyc && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_us_cmd_transmitter.sv
// Self-checking bench for us_cmd_transmitter: directed scenarios plus random
// traffic compared every cycle against a schedule-based reference model.
module tb_us_cmd_transmitter;
  import us_cmd_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HOLD   = 2;
  localparam int MAXO   = 5;
  localparam int SETTLE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic no_order = 1'b0;
  logic [14:0] received_data;
  logic        busy;
  logic [2:0]  outstanding;
  logic        drop_err;
  state_e      dbg_state;

  us_cmd_transmitter_if bus();

  us_cmd_transmitter #(
    .DATA_WIDTH(15), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD),
    .MAX_ORDERS(MAXO), .SETTLE(SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .req           (bus),
    .no_order      (no_order),
    .received_data (received_data),
    .busy          (busy),
    .outstanding   (outstanding),
    .drop_err      (drop_err),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_drops = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: exp_q holds the words the bus must show on upcoming
  // cycles; an empty plan means the bus rests (0 when off, idle word when on).
  logic [14:0] exp_q[$];
  logic [9:0]  fq[$];
  bit          m_on, m_shut;
  int          m_out, m_since;

  function automatic logic [14:0] cmd_word(int op, int amt);
    case (op)
      0:       return 15'(1 + 32 + 64);
      1:       return 15'(1 + 4 + 32 + 64 + amt * 128);
      2:       return 15'(1 + 8 + 32 + 64 + amt * 128);
      default: return 15'(1 + 16 + 64);
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fq.delete();
    m_on    = 0;
    m_shut  = 0;
    m_out   = 0;
    m_since = 0;
  endtask

  task automatic plan_cmd(int op, int amt);
    for (int i = 0; i < HOLD; i++) exp_q.push_back(cmd_word(op, amt));
    exp_q.push_back(15'h0001);
    m_shut = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [14:0] w;
    logic [9:0]  head;
    bit deciding, exp_drop, push, clr, send, cmd_now;
    @(negedge clk);
    w        = (exp_q.size() != 0) ? exp_q[0] : (m_on ? 15'h0001 : 15'h0000);
    deciding = (exp_q.size() == 0) && m_on && en && (fq.size() != 0);
    exp_drop = deciding && (fq[0][9:8] == 2'd3) && (m_out == 0);
    check("word", received_data, w);
    check("req_ready", bus.req_ready, fq.size() < DEPTH);
    check("busy", busy, (exp_q.size() != 0) || (fq.size() != 0));
    check("outstanding", outstanding, m_out);
    check("drop_err", drop_err, exp_drop);
    if (drop_err) n_drops++;

    push = bus.req_valid && (fq.size() < DEPTH);
    clr  = no_order && (m_since >= SETTLE);
    send = 0;
    if (exp_q.size() != 0) begin
      cmd_now = exp_q[0][6];
      if (cmd_now && !en) m_shut = 1;
      void'(exp_q.pop_front());
      if (cmd_now && exp_q.size() != 0 && !exp_q[0][6] && m_shut) begin
        exp_q.delete();
        exp_q.push_back(15'h0002);
        m_on = 0;
      end
    end else if (!m_on) begin
      if (en) begin
        exp_q.push_back(15'h0001);
        m_on = 1;
      end
    end else if (!en) begin
      exp_q.push_back(15'h0002);
      m_on = 0;
    end else if (fq.size() != 0) begin
      head = fq[0];
      if (head[9:8] == 2'd3) begin
        void'(fq.pop_front());
        if (m_out > 0) plan_cmd(3, 0);
      end else if (m_out < MAXO) begin
        void'(fq.pop_front());
        plan_cmd(int'(head[9:8]), int'(head[7:0]));
        send = 1;
      end
    end
    m_out   = (clr ? 0 : m_out) + (send ? 1 : 0);
    m_since = send ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
    if (!m_on && exp_q.size() == 0) m_out = 0;
    if (push) fq.push_back({bus.req_op, bus.req_amount});
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_req(int op, int amt);
    int tries;
    bit took;
    tries = 0;
    took  = 0;
    bus.req_valid  = 1'b1;
    bus.req_op     = op_e'(op);
    bus.req_amount = 8'(amt);
    do begin
      took = (fq.size() < DEPTH);
      cycle();
      tries++;
    end while (!took && tries < 64);
    check("push_accept", took, 1);
    bus.req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_HOLD;
    bus.req_amount = 8'h00;
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    check("rst_word", received_data, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_drop", drop_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // power-up: one WAKE cycle, then the idle word
    en = 1'b1;
    cycle();
    check("wake_state", dbg_state, ST_WAKE);
    check("wake_word", received_data, 15'h0001);
    run(2);
    check("idle_word", received_data, 15'h0001);

    // single INC of 3
    push_req(1, 8'h03);
    cycle();
    check("inc_word0", received_data, 15'h01E5);
    check("inc_outstanding", outstanding, 1);
    cycle();
    check("inc_word1", received_data, 15'h01E5);
    cycle();
    check("gap_word", received_data, 15'h0001);

    // six INCs against MAX_ORDERS, then release with no_order
    no_order = 1'b1;
    run(6);
    check("cleared", outstanding, 0);
    no_order = 1'b0;
    for (int i = 1; i <= 6; i++) push_req(1, i);
    run(40);
    check("stall_outstanding", outstanding, MAXO);
    check("stall_busy", busy, 1);
    check("stall_word", received_data, 15'h0001);
    no_order = 1'b1;
    run(2);
    check("sixth_word", received_data, cmd_word(1, 6));
    check("sixth_outstanding", outstanding, 1);
    no_order = 1'b0;
    run(10);

    // RECV with nothing outstanding is dropped
    no_order = 1'b1;
    run(8);
    check("pre_recv_outstanding", outstanding, 0);
    no_order = 1'b0;
    d0 = n_drops;
    push_req(3, 8'h55);
    run(4);
    check("drop_count", n_drops - d0, 1);
    check("drop_word", received_data, 15'h0001);

    // shutdown requested in the middle of a DEC hold
    push_req(2, 8'h0A);
    cycle();
    check("dec_word0", received_data, cmd_word(2, 10));
    check("dec_outstanding", outstanding, 1);
    en = 1'b0;
    cycle();
    check("dec_word1", received_data, cmd_word(2, 10));
    cycle();
    check("shut_word", received_data, 15'h0002);
    cycle();
    check("off_word", received_data, 15'h0000);
    check("off_outstanding", outstanding, 0);

    // fill the FIFO while off, then async reset mid-ISSUE
    push_req(0, 0);
    push_req(1, 7);
    push_req(2, 9);
    push_req(3, 0);
    check("full_ready", bus.req_ready, 0);
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_INC;
    bus.req_amount = 8'h11;
    run(2);
    bus.req_valid = 1'b0;
    check("full_busy", busy, 1);
    en = 1'b1;
    run(3);
    check("hold_word", received_data, 15'h0061);
    #2 rst_n = 1'b0;
    #1;
    check("arst_word", received_data, 0);
    check("arst_ready", bus.req_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_state", dbg_state, ST_OFF);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_op     = op_e'($urandom_range(0, 3));
      bus.req_amount = 8'($urandom_range(0, 255));
      no_order       = ($urandom_range(0, 3) == 0);
      en             = ($urandom_range(0, 99) < 97);
      cycle();
    end
    bus.req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
